int_to_fp_converter: RTL and testbench

Multi-cycle converter from a 32-bit integer (signed two's-complement or unsigned) to IEEE-754 single precision, rounded to nearest, ties to even. It sits directly upstream of the FP adder/subtractor and produces its a/b operands from integer datapath values. It uses the same start/done handshake and one-shift-per-cycle iterative normalisation style as the FP adder/subtractor.

---
 rtl/int_to_fp_converter.sv | 124 ++++++++++++
 tb/tb_int_to_fp_converter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/int_to_fp_converter.sv
// Multi-cycle 32-bit integer (signed or unsigned) to IEEE-754 binary32 converter.
// Round to nearest, ties to even; normalises one bit position per cycle.
module int_to_fp_converter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic        is_signed,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_UNPACK    = 3'd1;
    localparam logic [2:0] ST_NORMALIZE = 3'd2;
    localparam logic [2:0] ST_ROUND     = 3'd3;
    localparam logic [2:0] ST_PACK      = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    logic [2:0]  state_r;
    logic [31:0] a_r;
    logic        is_signed_r;
    logic        sign_r;
    logic [31:0] mag_r;
    logic [7:0]  exp_r;
    logic [22:0] mant_r;
    logic        zero_r;

    logic [22:0] mant_s;
    logic        guard_s;
    logic        sticky_s;
    logic        inc_s;
    logic [23:0] mant_sum_s;

    // Round-to-nearest-even increment decision from lsb, guard and sticky bits.
    function automatic logic rne_increment(input logic lsb, input logic guard, input logic sticky);
        return guard & (sticky | lsb);
    endfunction

    assign busy = (state_r != ST_IDLE);

    // Rounding datapath on the normalised magnitude.
    always_comb begin
        mant_s     = mag_r[30:8];
        guard_s    = mag_r[7];
        sticky_s   = |mag_r[6:0];
        inc_s      = rne_increment(mant_s[0], guard_s, sticky_s);
        mant_sum_s = {1'b0, mant_s} + 24'd1;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            a_r         <= 32'd0;
            is_signed_r <= 1'b0;
            sign_r      <= 1'b0;
            mag_r       <= 32'd0;
            exp_r       <= 8'd0;
            mant_r      <= 23'd0;
            zero_r      <= 1'b0;
            result      <= 32'd0;
            done        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_r         <= a;
                        is_signed_r <= is_signed;
                        state_r     <= ST_UNPACK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_UNPACK: begin
                    sign_r <= is_signed_r & a_r[31];
                    // Negating 0x80000000 yields 0x80000000, which is the correct magnitude.
                    mag_r  <= (is_signed_r & a_r[31]) ? (~a_r + 32'd1) : a_r;
                    exp_r  <= 8'd158;
                    zero_r <= (a_r == 32'd0);
                    if (a_r == 32'd0) begin
                        state_r <= ST_PACK;
                    end else begin
                        state_r <= ST_NORMALIZE;
                    end
                end
                ST_NORMALIZE: begin
                    if (!mag_r[31]) begin
                        mag_r   <= {mag_r[30:0], 1'b0};
                        exp_r   <= exp_r - 8'd1;
                        state_r <= ST_NORMALIZE;
                    end else begin
                        state_r <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (inc_s) begin
                        // A carry out of the mantissa bumps the exponent; the mantissa wraps to zero.
                        mant_r <= mant_sum_s[22:0];
                        exp_r  <= exp_r + {7'd0, mant_sum_s[23]};
                    end else begin
                        mant_r <= mant_s;
                    end
                    state_r <= ST_PACK;
                end
                ST_PACK: begin
                    result  <= zero_r ? 32'h0000_0000 : {sign_r, exp_r, mant_r};
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Directed-vector self-checking bench for int_to_fp_converter.
module tb_int_to_fp_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic        is_signed;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int checks;
    int errors;

    int_to_fp_converter dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .is_signed (is_signed),
        .result    (result),
        .done      (done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks++;
        if (obs !== exp_val) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_val);
        end
    endtask

    // Run one conversion; optionally pulse a second start (junk operand) at cycle intrude_at.
    task automatic run_conv(input string tag, input logic [31:0] op, input logic sgn,
                            input logic [31:0] exp_res, input int exp_lat, input int intrude_at);
        int  n;
        bit  seen;
        bit  busy_ok;
        @(negedge clk);
        a         = op;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = 32'hDEAD_BEEF;
        n       = 0;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 60) begin
            if (n == intrude_at) begin
                a         = 32'hFFFF_FFFF;
                is_signed = 1'b0;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_val({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        check_val({tag, " latency"}, n, exp_lat);
        check_val({tag, " busy_during"}, {31'd0, busy_ok}, 32'd1);
        check_val({tag, " result"}, result, exp_res);
        @(posedge clk);
        #1;
        check_val({tag, " done_pulse_width"}, {31'd0, done}, 32'd0);
        if (intrude_at >= 0) begin
            seen = 1'b0;
            for (int i = 0; i < 45; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) seen = 1'b1;
            end
            check_val({tag, " ignored_start_not_queued"}, {31'd0, seen}, 32'd0);
            check_val({tag, " result_held"}, result, exp_res);
        end
    endtask

    initial begin
        bit late_done;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        start     = 1'b0;
        a         = 32'd0;
        is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset result", result, 32'd0);
        check_val("reset done", {31'd0, done}, 32'd0);
        check_val("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_conv("one_s",        32'h0000_0001, 1'b1, 32'h3F80_0000, 36, -1);
        run_conv("neg1_s",       32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 36, -1);
        run_conv("max_u",        32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 5,  -1);
        run_conv("minint_s",     32'h8000_0000, 1'b1, 32'hCF00_0000, 5,  -1);
        run_conv("msb_u",        32'h8000_0000, 1'b0, 32'h4F00_0000, 5,  -1);
        run_conv("maxint_s",     32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 6,  -1);
        run_conv("tie_even_dn",  32'h0100_0001, 1'b0, 32'h4B80_0000, 12, -1);
        run_conv("tie_odd_up",   32'h0100_0003, 1'b0, 32'h4B80_0002, 12, -1);
        // 2^24+5 lies midway between 2^24+4 (even mantissa 2) and 2^24+6: rounds to mantissa 2.
        run_conv("tie_even_dn2", 32'h0100_0005, 1'b0, 32'h4B80_0002, 12, -1);
        run_conv("zero_s",       32'h0000_0000, 1'b1, 32'h0000_0000, 3,  -1);
        run_conv("intrude",      32'h0100_0003, 1'b1, 32'h4B80_0002, 12, 4);

        // Reset while normalising a=1.
        @(negedge clk);
        a         = 32'h0000_0001;
        is_signed = 1'b1;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_val("midreset result", result, 32'd0);
        check_val("midreset done", {31'd0, done}, 32'd0);
        check_val("midreset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        late_done = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) late_done = 1'b1;
        end
        check_val("midreset no_late_done", {31'd0, late_done}, 32'd0);
        run_conv("five_after_reset", 32'h0000_0005, 1'b1, 32'h40A0_0000, 34, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
